// File: rtl/adder_pkg.sv
// adder_pkg: shared state encoding and sizing helper for the serial adder.
package adder_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} adder_state_t;

    function automatic int cnt_width(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/adder_1bit.sv
// adder_1bit: single-bit full adder, one link of the per-cycle ripple chain.
module adder_1bit (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

// File: rtl/adder_serial_nbit.sv
// adder_serial_nbit: multi-cycle adder consuming BITS_PER_CYCLE operand bits per clock,
// LSB chunk first, reporting sum, carry-out and signed overflow with a one-cycle done pulse.
module adder_serial_nbit
    import adder_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int B     = BITS_PER_CYCLE;
    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CW    = cnt_width(STEPS);

    adder_state_t     state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, psum_q, psum_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [B:0]       chain_c;
    logic [B-1:0]     chunk_s;
    logic [WIDTH-1:0] psum_next;
    logic             accept, last;

    assign chain_c[0] = carry_q;

    for (genvar i = 0; i < B; i++) begin : g_fa
        adder_1bit u_fa (
            .a        (a_q[i]),
            .b        (b_q[i]),
            .carry_in (chain_c[i]),
            .sum      (chunk_s[i]),
            .carry_out(chain_c[i+1])
        );
    end

    assign accept    = (state_q != RUN) && start;
    assign last      = (state_q == RUN) && (cnt_q == CW'(STEPS - 1));
    // New chunk enters at the MSB end; after STEPS shifts the LSB chunk sits at bit 0.
    assign psum_next = WIDTH'({chunk_s, psum_q} >> B);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (accept) begin
            state_d = RUN;
            cnt_d   = '0;
            a_d     = a;
            b_d     = b;
            carry_d = carry_in;
            psum_d  = '0;
        end else if (state_q == RUN) begin
            a_d     = a_q >> B;
            b_d     = b_q >> B;
            carry_d = chain_c[B];
            psum_d  = psum_next;
            cnt_d   = last ? '0 : cnt_q + CW'(1);
            if (last) begin
                state_d = DONE;
                sum_d   = psum_next;
                cout_d  = chain_c[B];
                ovf_d   = chain_c[B] ^ chain_c[B-1];
            end
        end else begin
            state_d = IDLE;
        end
        busy_d = (state_d == RUN);
        done_d = last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            psum_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule
